i2c_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one I2CController instance between N requesters (sensor poller, DAC config, debug UART bridge).
- Latches the winning requester's transaction, drives the controller's start/op/address/data inputs, and tracks BUSY to completion.
- Returns the RX word and NACK status to the granted requester with a one-cycle done pulse.
- Sits between the requester blocks and the I2CController.

---
 rtl/i2c_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2CController among N requesters.
// Optional macro I2C_ARB_RETRY_EN: retry a NACKed transfer up to twice and report retry_cnt.
module i2c_bus_arbiter #(
    parameter int N             = 3,
    parameter int START_TIMEOUT = 64,
    localparam int PTR_W        = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      req_op,
    input  logic [2*N-1:0]    req_bytes,
    input  logic [7*N-1:0]    req_addr,
    input  logic [16*N-1:0]   req_data,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic [15:0]       rx_data,
    output logic              rx_nack,
    output logic              rx_timeout,
    output logic              i2c_start,
    output logic              i2c_op,
    output logic [1:0]        i2c_bytes,
    output logic [6:0]        i2c_addr,
    output logic [15:0]       i2c_tx,
    input  logic              i2c_busy,
    input  logic              i2c_nack,
    input  logic [15:0]       i2c_rx
`ifdef I2C_ARB_RETRY_EN
    ,
    output logic [1:0]        retry_cnt
`endif
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t             stateReg;
    logic [PTR_W-1:0]   ptrReg;
    logic [PTR_W-1:0]   winReg;
    logic [CNT_W-1:0]   cntReg;
    logic [PTR_W-1:0]   winIdx;
    logic [PTR_W-1:0]   cand;
    logic               anyReq;

    // Scan from the highest offset down so the lowest offset from ptrReg wins.
    always_comb begin
        anyReq = 1'b0;
        winIdx = '0;
        cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptrReg) + k) % N);
            if (req[cand]) begin
                anyReq = 1'b1;
                winIdx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= IDLE;
            ptrReg     <= '0;
            winReg     <= '0;
            cntReg     <= '0;
            grant      <= '0;
            done       <= '0;
            rx_data    <= '0;
            rx_nack    <= 1'b0;
            rx_timeout <= 1'b0;
            i2c_start  <= 1'b0;
            i2c_op     <= 1'b0;
            i2c_bytes  <= '0;
            i2c_addr   <= '0;
            i2c_tx     <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            done <= '0;
            case (stateReg)
                IDLE: begin
                    if (anyReq) begin
                        grant     <= N'(1) << winIdx;
                        winReg    <= winIdx;
                        i2c_op    <= req_op[winIdx];
                        i2c_bytes <= req_bytes[2*winIdx +: 2];
                        i2c_addr  <= req_addr[7*winIdx +: 7];
                        i2c_tx    <= req_data[16*winIdx +: 16];
                        i2c_start <= 1'b1;
                        cntReg    <= '0;
`ifdef I2C_ARB_RETRY_EN
                        retry_cnt <= '0;
`endif
                        stateReg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i2c_busy) begin
                        i2c_start <= 1'b0;
                        stateReg  <= WAIT;
                    end else if (cntReg == CNT_LAST) begin
                        // Controller never acknowledged the start: abort, keep old rx_data.
                        i2c_start  <= 1'b0;
                        rx_timeout <= 1'b1;
                        rx_nack    <= 1'b0;
                        done       <= N'(1) << winReg;
                        grant      <= '0;
                        stateReg   <= FINISH;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end
                WAIT: begin
                    if (!i2c_busy) begin
`ifdef I2C_ARB_RETRY_EN
                        if (i2c_nack && retry_cnt != 2'd2) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            i2c_start <= 1'b1;
                            cntReg    <= '0;
                            stateReg  <= ISSUE;
                        end else
`endif
                        begin
                            rx_data    <= i2c_rx;
                            rx_nack    <= i2c_nack;
                            rx_timeout <= 1'b0;
                            done       <= N'(1) << winReg;
                            grant      <= '0;
                            stateReg   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    ptrReg   <= (winReg == PTR_LAST) ? '0 : winReg + 1'b1;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter (N=3, START_TIMEOUT=64).
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, req_op;
    logic [5:0]  req_bytes;
    logic [20:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  grant, done;
    logic [15:0] rx_data;
    logic        rx_nack, rx_timeout;
    logic        i2c_start, i2c_op;
    logic [1:0]  i2c_bytes;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_tx;
    logic        i2c_busy, i2c_nack;
    logic [15:0] i2c_rx;
`ifdef I2C_ARB_RETRY_EN
    logic [1:0]  retry_cnt;
`endif

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.N(3), .START_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_op(req_op), .req_bytes(req_bytes),
        .req_addr(req_addr), .req_data(req_data),
        .grant(grant), .done(done),
        .rx_data(rx_data), .rx_nack(rx_nack), .rx_timeout(rx_timeout),
        .i2c_start(i2c_start), .i2c_op(i2c_op), .i2c_bytes(i2c_bytes),
        .i2c_addr(i2c_addr), .i2c_tx(i2c_tx),
        .i2c_busy(i2c_busy), .i2c_nack(i2c_nack), .i2c_rx(i2c_rx)
`ifdef I2C_ARB_RETRY_EN
        , .retry_cnt(retry_cnt)
`endif
    );

    task automatic test_reset();
        rst = 1'b1; req = '0; req_op = '0; req_bytes = '0; req_addr = '0; req_data = '0;
        i2c_busy = 1'b0; i2c_nack = 1'b0; i2c_rx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vecCount++;
        if (grant !== 3'b000 || done !== 3'b000 || i2c_start !== 1'b0) begin
            errCount++;
            $display("FAIL reset_ctrl: grant=%b done=%b start=%b, required 000 000 0", grant, done, i2c_start);
        end
        vecCount++;
        if (rx_data !== 16'h0 || rx_nack !== 1'b0 || rx_timeout !== 1'b0 || i2c_addr !== 7'h0 || i2c_tx !== 16'h0) begin
            errCount++;
            $display("FAIL reset_data: rx=%h nack=%b to=%b addr=%h tx=%h, required all zero",
                     rx_data, rx_nack, rx_timeout, i2c_addr, i2c_tx);
        end
        $display("txn reset: done");
    endtask

    task automatic test_single_write();
        req[0] = 1'b1; req_op[0] = 1'b0; req_bytes[1:0] = 2'd1;
        req_addr[6:0] = 7'h25; req_data[15:0] = 16'h550F;
        @(negedge clk);
        vecCount++;
        if (grant !== 3'b001 || i2c_start !== 1'b1) begin
            errCount++;
            $display("FAIL wr_grant: grant=%b start=%b, required 001 1", grant, i2c_start);
        end
        vecCount++;
        if (i2c_addr !== 7'h25 || i2c_tx !== 16'h550F || i2c_bytes !== 2'd1 || i2c_op !== 1'b0) begin
            errCount++;
            $display("FAIL wr_fields: addr=%h tx=%h bytes=%0d op=%b, required 25 550f 1 0",
                     i2c_addr, i2c_tx, i2c_bytes, i2c_op);
        end
        // Changes after grant must not reach the controller.
        req[0] = 1'b0; req_addr[6:0] = 7'h7F; req_data[15:0] = 16'hFFFF;
        @(negedge clk);
        vecCount++;
        if (i2c_start !== 1'b1 || grant !== 3'b001 || i2c_addr !== 7'h25 || i2c_tx !== 16'h550F) begin
            errCount++;
            $display("FAIL wr_hold: start=%b grant=%b addr=%h tx=%h, required 1 001 25 550f",
                     i2c_start, grant, i2c_addr, i2c_tx);
        end
        i2c_busy = 1'b1;
        @(negedge clk);
        vecCount++;
        if (i2c_start !== 1'b0 || grant !== 3'b001) begin
            errCount++;
            $display("FAIL wr_busy: start=%b grant=%b, required 0 001", i2c_start, grant);
        end
        repeat (2) @(negedge clk);
        i2c_busy = 1'b0; i2c_nack = 1'b0; i2c_rx = 16'h1234;
        @(negedge clk);
        vecCount++;
        if (done !== 3'b001 || grant !== 3'b000 || rx_nack !== 1'b0) begin
            errCount++;
            $display("FAIL wr_done: done=%b grant=%b nack=%b, required 001 000 0", done, grant, rx_nack);
        end
        @(negedge clk);
        vecCount++;
        if (done !== 3'b000) begin
            errCount++;
            $display("FAIL wr_pulse: done=%b, required 000", done);
        end
        $display("txn write: addr=%h tx=%h nack=%b", 7'h25, 16'h550F, rx_nack);
    endtask

    task automatic test_read();
        req[1] = 1'b1; req_op[1] = 1'b1; req_bytes[3:2] = 2'd2;
        req_addr[13:7] = 7'h24; req_data[31:16] = 16'h0000;
        @(negedge clk);
        vecCount++;
        if (grant !== 3'b010 || i2c_op !== 1'b1 || i2c_addr !== 7'h24 || i2c_bytes !== 2'd2) begin
            errCount++;
            $display("FAIL rd_grant: grant=%b op=%b addr=%h bytes=%0d, required 010 1 24 2",
                     grant, i2c_op, i2c_addr, i2c_bytes);
        end
        req[1] = 1'b0; i2c_busy = 1'b1;
        @(negedge clk);
        i2c_busy = 1'b0; i2c_rx = 16'hCE11; i2c_nack = 1'b0;
        @(negedge clk);
        vecCount++;
        if (done !== 3'b010 || rx_data !== 16'hCE11 || rx_nack !== 1'b0 || rx_timeout !== 1'b0) begin
            errCount++;
            $display("FAIL rd_done: done=%b rx=%h nack=%b to=%b, required 010 ce11 0 0",
                     done, rx_data, rx_nack, rx_timeout);
        end
        i2c_rx = 16'h5A5A;
        @(negedge clk);
        vecCount++;
        if (done !== 3'b000 || rx_data !== 16'hCE11) begin
            errCount++;
            $display("FAIL rd_hold: done=%b rx=%h, required 000 ce11", done, rx_data);
        end
        $display("txn read: addr=%h rx=%h", 7'h24, rx_data);
    endtask

    task automatic test_timeout();
        int highCnt;
        req[2] = 1'b1; req_addr[20:14] = 7'h11; i2c_rx = 16'hDEAD;
        @(negedge clk);
        vecCount++;
        if (grant !== 3'b100) begin
            errCount++;
            $display("FAIL to_grant: grant=%b, required 100", grant);
        end
        req[2] = 1'b0;
        highCnt = 0;
        while (i2c_start === 1'b1 && highCnt < 100) begin
            highCnt++;
            @(negedge clk);
        end
        vecCount++;
        if (highCnt != 64) begin
            errCount++;
            $display("FAIL to_len: start high %0d cycles, required 64", highCnt);
        end
        vecCount++;
        if (done !== 3'b100 || rx_timeout !== 1'b1 || rx_nack !== 1'b0 || rx_data !== 16'hCE11) begin
            errCount++;
            $display("FAIL to_done: done=%b to=%b nack=%b rx=%h, required 100 1 0 ce11",
                     done, rx_timeout, rx_nack, rx_data);
        end
        @(negedge clk);
        vecCount++;
        if (done !== 3'b000 || rx_timeout !== 1'b1) begin
            errCount++;
            $display("FAIL to_hold: done=%b to=%b, required 000 1", done, rx_timeout);
        end
        $display("txn timeout: start cycles=%0d", highCnt);
    endtask

    task automatic test_contention();
        int gap;
        logic [2:0] expGrant;
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            expGrant = 3'b001 << (t % 3);
            gap = 0;
            @(negedge clk);
            while (grant === 3'b000 && gap < 10) begin
                gap++;
                @(negedge clk);
            end
            vecCount++;
            if (grant !== expGrant || gap != (t == 0 ? 0 : 1)) begin
                errCount++;
                $display("FAIL cont_grant%0d: grant=%b gap=%0d, required %b gap %0d",
                         t, grant, gap, expGrant, (t == 0 ? 0 : 1));
            end
            i2c_busy = 1'b1;
            @(negedge clk);
            i2c_busy = 1'b0; i2c_rx = 16'hA000 + 16'(t);
            @(negedge clk);
            vecCount++;
            if (done !== expGrant || rx_data !== 16'hA000 + 16'(t) || rx_timeout !== 1'b0) begin
                errCount++;
                $display("FAIL cont_done%0d: done=%b rx=%h to=%b, required %b %h 0",
                         t, done, rx_data, rx_timeout, expGrant, 16'hA000 + 16'(t));
            end
            $display("txn contention %0d: grant=%b rx=%h", t, expGrant, rx_data);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        req = 3'b011;
        @(negedge clk);
        vecCount++;
        if (grant !== 3'b010) begin
            errCount++;
            $display("FAIL rst_pre: grant=%b, required 010", grant);
        end
        i2c_busy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i2c_busy = 1'b0;
        vecCount++;
        if (grant !== 3'b000 || i2c_start !== 1'b0 || done !== 3'b000 || rx_timeout !== 1'b0) begin
            errCount++;
            $display("FAIL rst_mid: grant=%b start=%b done=%b to=%b, required 000 0 000 0",
                     grant, i2c_start, done, rx_timeout);
        end
        @(negedge clk);
        vecCount++;
        if (grant !== 3'b001 || i2c_start !== 1'b1 || done !== 3'b000) begin
            errCount++;
            $display("FAIL rst_rearb: grant=%b start=%b done=%b, required 001 1 000", grant, i2c_start, done);
        end
        req = 3'b000; i2c_busy = 1'b1;
        @(negedge clk);
        i2c_busy = 1'b0;
        @(negedge clk);
        vecCount++;
        if (done !== 3'b001) begin
            errCount++;
            $display("FAIL rst_done: done=%b, required 001", done);
        end
        @(negedge clk);
        $display("txn reset-mid-wait: regrant from index 0");
    endtask

`ifdef I2C_ARB_RETRY_EN
    task automatic test_retry();
        int starts;
        int cyc;
        starts = 0; cyc = 0;
        req = 3'b001;
        @(negedge clk);
        req = 3'b000;
        while (done === 3'b000 && cyc < 40) begin
            if (i2c_start === 1'b1 && i2c_busy === 1'b0) begin
                starts++;
                i2c_busy = 1'b1;
            end else if (i2c_busy === 1'b1) begin
                i2c_busy = 1'b0; i2c_nack = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        vecCount++;
        if (starts != 3 || done !== 3'b001 || rx_nack !== 1'b1 || retry_cnt !== 2'd2) begin
            errCount++;
            $display("FAIL retry: starts=%0d done=%b nack=%b retries=%0d, required 3 001 1 2",
                     starts, done, rx_nack, retry_cnt);
        end
        i2c_nack = 1'b0;
        @(negedge clk);
        $display("txn retry: starts=%0d", starts);
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_timeout();
        test_contention();
        test_reset_mid_wait();
`ifdef I2C_ARB_RETRY_EN
        test_retry();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
